// File: rtl/cache_axi_responder_pkg.sv
// Shared types and constants for the L1-cache-to-AXI3 responder.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RET
  } state_e;

  // Cache size encoding: bit0=byte, bit1=half, anything else=word
  localparam logic [2:0] SZ_BYTE     = 3'b001;
  localparam logic [2:0] SZ_HALF     = 3'b010;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] AXSIZE_1    = 3'd0;
  localparam logic [2:0] AXSIZE_2    = 3'd1;
  localparam logic [2:0] AXSIZE_4    = 3'd2;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

endpackage

// File: rtl/cache_axi_responder_if.sv
// AXI3 bus bundle between the cache responder (master) and the SoC fabric (slave).
interface cache_axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/cache_axi_responder_size_strb.sv
// Maps the cache size code and low address bits to AXI axsize and write strobes.
module axi_size_strb
  import cache_axi_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [2:0] o_axsize,
  output logic [3:0] o_wstrb
);

  logic w_unused;
  assign w_unused = i_size[2];

  always_comb begin
    o_axsize = AXSIZE_4;
    o_wstrb  = 4'b1111;
    if ((i_size & SZ_BYTE) != 3'b000) begin
      o_axsize = AXSIZE_1;
      o_wstrb  = 4'b0001 << i_addr;
    end else if ((i_size & SZ_HALF) != 3'b000) begin
      o_axsize = AXSIZE_2;
      o_wstrb  = i_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

endmodule

// File: rtl/cache_axi_responder.sv
// Bridges inst/data cache call/return handshakes onto single-beat AXI3 transactions,
// one outstanding at a time, data side given priority.
module cache_axi_responder
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_interface_call_begin,
  input  logic [31:0] inst_interface_addr,
  output logic        inst_interface_return_ready,
  output logic [31:0] inst_interface_rdata,
  input  logic        data_interface_enable,
  input  logic        data_interface_call_begin,
  input  logic        write_enable,
  input  logic [2:0]  read_size,
  input  logic [2:0]  write_size,
  input  logic [31:0] data_interface_raddr,
  input  logic [31:0] data_interface_waddr,
  input  logic [31:0] data_interface_wdata,
  output logic        data_interface_return_ready,
  output logic [31:0] data_interface_rdata,
  cache_axi_if.master axi
);

  state_e      r_state;
  logic        r_inst_pend, r_data_pend, r_we, r_sel_data;
  logic [31:0] r_inst_addr, r_daddr, r_req_wdata;
  logic [2:0]  r_size;
  logic        r_inst_rr, r_data_rr;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic [3:0]  r_arid, r_awid, r_wstrb;
  logic [31:0] r_araddr, r_awaddr, r_wdata;
  logic [2:0]  r_arsize, r_awsize;
  logic [1:0]  r_arburst, r_awburst;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
  logic [2:0]  w_axsize;
  logic [3:0]  w_wstrb;
  logic        w_inst_clr, w_data_clr, w_unused;

  axi_size_strb u_size_strb (
    .i_size   (r_size),
    .i_addr   (r_daddr[1:0]),
    .o_axsize (w_axsize),
    .o_wstrb  (w_wstrb)
  );

  assign w_inst_clr = (r_state == S_RET) && !r_sel_data;
  assign w_data_clr = (r_state == S_RET) &&  r_sel_data;
  assign w_unused   = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  // A call from a source whose request is still pending is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst_pend <= 1'b0;
      r_inst_addr <= '0;
      r_data_pend <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_daddr     <= '0;
      r_req_wdata <= '0;
    end else begin
      if (w_inst_clr)
        r_inst_pend <= 1'b0;
      else if (inst_interface_call_begin && !r_inst_pend) begin
        r_inst_pend <= 1'b1;
        r_inst_addr <= inst_interface_addr;
      end
      if (w_data_clr)
        r_data_pend <= 1'b0;
      else if (data_interface_call_begin && data_interface_enable && !r_data_pend) begin
        r_data_pend <= 1'b1;
        r_we        <= write_enable;
        r_size      <= write_enable ? write_size : read_size;
        r_daddr     <= write_enable ? data_interface_waddr : data_interface_raddr;
        r_req_wdata <= data_interface_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sel_data   <= 1'b0;
      r_inst_rr    <= 1'b0;
      r_data_rr    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_awsize     <= '0;
      r_awburst    <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wlast      <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else begin
      r_inst_rr <= 1'b0;
      r_data_rr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_data_pend) begin
            r_sel_data <= 1'b1;
            if (r_we) begin
              r_awid    <= DATA_ID;
              r_awaddr  <= r_daddr;
              r_awsize  <= w_axsize;
              r_awburst <= BURST_INCR;
              r_awvalid <= 1'b1;
              r_wdata   <= r_req_wdata;
              r_wstrb   <= w_wstrb;
              r_wlast   <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_arid    <= DATA_ID;
              r_araddr  <= r_daddr;
              r_arsize  <= w_axsize;
              r_arburst <= BURST_INCR;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end else if (r_inst_pend) begin
            r_sel_data <= 1'b0;
            r_arid     <= INST_ID;
            r_araddr   <= r_inst_addr;
            r_arsize   <= AXSIZE_4;
            r_arburst  <= BURST_INCR;
            r_arvalid  <= 1'b1;
            r_state    <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: if (axi.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (axi.rvalid) begin
          r_rready <= 1'b0;
          if (r_sel_data) r_data_rdata <= axi.rdata;
          else            r_inst_rdata <= axi.rdata;
          r_state <= S_RET;
        end
        S_WR_REQ: begin
          // aw and w channels retire independently; move on once both are gone
          if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi.wready)   r_wvalid  <= 1'b0;
          if ((!r_awvalid || axi.awready) && (!r_wvalid || axi.wready)) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: if (axi.bvalid) begin
          r_bready <= 1'b0;
          r_state  <= S_RET;
        end
        S_RET: begin
          if (r_sel_data) r_data_rr <= 1'b1;
          else            r_inst_rr <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_interface_return_ready = r_inst_rr;
  assign inst_interface_rdata        = r_inst_rdata;
  assign data_interface_return_ready = r_data_rr;
  assign data_interface_rdata        = r_data_rdata;

  assign axi.arid    = r_arid;
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = r_arsize;
  assign axi.arburst = r_arburst;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign axi.awid    = r_awid;
  assign axi.awaddr  = r_awaddr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = r_awsize;
  assign axi.awburst = r_awburst;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = r_wlast;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

endmodule

// File: tb/tb_cache_axi_responder.sv
// Directed bench: a scripted AXI slave serves fetches, loads and stores with chosen delays.
module tb_cache_axi_responder;
  import cache_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_cb;
  logic [31:0] inst_addr;
  logic        inst_rr;
  logic [31:0] inst_rdata;
  logic        data_en, data_cb, we;
  logic [2:0]  rsize, wsize;
  logic [31:0] raddr, waddr, wdata;
  logic        data_rr;
  logic [31:0] data_rdata;

  int n_tests = 0, n_fail = 0;
  int inst_pulses = 0, data_pulses = 0, seq = 0, inst_seq = 0, data_seq = 0;
  int ip0, dp0;

  always #5 clk = ~clk;

  cache_axi_if axi ();

  cache_axi_responder dut (
    .clk                         (clk),
    .reset                       (reset),
    .inst_interface_call_begin   (inst_cb),
    .inst_interface_addr         (inst_addr),
    .inst_interface_return_ready (inst_rr),
    .inst_interface_rdata        (inst_rdata),
    .data_interface_enable       (data_en),
    .data_interface_call_begin   (data_cb),
    .write_enable                (we),
    .read_size                   (rsize),
    .write_size                  (wsize),
    .data_interface_raddr        (raddr),
    .data_interface_waddr        (waddr),
    .data_interface_wdata        (wdata),
    .data_interface_return_ready (data_rr),
    .data_interface_rdata        (data_rdata),
    .axi                         (axi)
  );

  // Pulse monitor: counts high cycles and records completion order
  always @(negedge clk) begin
    if (inst_rr) begin inst_pulses++; seq++; inst_seq = seq; end
    if (data_rr) begin data_pulses++; seq++; data_seq = seq; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch_req(input logic [31:0] a);
    inst_cb = 1'b1; inst_addr = a;
    tick();
    inst_cb = 1'b0;
  endtask

  task automatic data_req(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    data_cb = 1'b1; data_en = 1'b1; we = w;
    rsize = sz; wsize = sz; raddr = a; waddr = a; wdata = d;
    tick();
    data_cb = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    while (!axi.arvalid && n < 40) begin tick(); n++; end
    chk("ar_arrive", axi.arvalid, 1);
  endtask

  task automatic wait_aw();
    int n = 0;
    while (!axi.awvalid && n < 40) begin tick(); n++; end
    chk("aw_arrive", axi.awvalid, 1);
  endtask

  task automatic serve_read(input int ard, input logic [31:0] d);
    for (int k = 0; k < ard; k++) begin
      tick();
      chk("arvalid_hold", axi.arvalid, 1);
    end
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    chk("rready", axi.rready, 1);
    chk("arvalid_drop", axi.arvalid, 0);
    axi.rvalid = 1'b1; axi.rdata = d; tick(); axi.rvalid = 1'b0;
  endtask

  task automatic serve_write(input int awd, input int wd);
    int last;
    last = (awd > wd) ? awd : wd;
    chk("wvalid_with_aw", axi.wvalid, 1);
    for (int k = 0; k <= last; k++) begin
      axi.awready = (k == awd); axi.wready = (k == wd);
      tick();
      if (k < wd) chk("bready_early", axi.bready, 0);
      if (k == awd && k < wd) begin
        chk("awvalid_drop", axi.awvalid, 0);
        chk("wvalid_hold", axi.wvalid, 1);
      end
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("bready", axi.bready, 1);
    chk("wvalid_drop", axi.wvalid, 0);
    axi.bvalid = 1'b1; axi.bresp = 2'b10; tick(); axi.bvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    inst_cb = 0; inst_addr = 0; data_en = 0; data_cb = 0; we = 0;
    rsize = 0; wsize = 0; raddr = 0; waddr = 0; wdata = 0;
    axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
    tick(); tick();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_inst_rr", inst_rr, 0);
    chk("rst_data_rdata", data_rdata, 0);
    reset = 1'b1;
    tick();

    // Fetch with arready two cycles late
    ip0 = inst_pulses; dp0 = data_pulses;
    fetch_req(32'h0000_1004);
    wait_ar();
    chk("f_araddr", axi.araddr, 32'h0000_1004);
    chk("f_arsize", axi.arsize, 2);
    chk("f_arid", axi.arid, 0);
    chk("f_arlen", axi.arlen, 0);
    chk("f_arburst", axi.arburst, 1);
    serve_read(2, 32'h2408_0001);
    repeat (3) tick();
    chk("f_inst_pulses", inst_pulses - ip0, 1);
    chk("f_data_pulses", data_pulses - dp0, 0);
    chk("f_rdata", inst_rdata, 32'h2408_0001);

    // Byte store at offset 3, aw before w
    ip0 = inst_pulses; dp0 = data_pulses;
    data_req(1'b1, 3'b001, 32'h0000_2003, 32'hAB00_0000);
    wait_aw();
    chk("sb_awaddr", axi.awaddr, 32'h0000_2003);
    chk("sb_awsize", axi.awsize, 0);
    chk("sb_wstrb", axi.wstrb, 4'b1000);
    chk("sb_wdata", axi.wdata, 32'hAB00_0000);
    chk("sb_awid", axi.awid, 1);
    chk("sb_wlast", axi.wlast, 1);
    serve_write(0, 1);
    repeat (3) tick();
    chk("sb_data_pulses", data_pulses - dp0, 1);
    chk("sb_inst_pulses", inst_pulses - ip0, 0);

    // Half store in upper lane, w before aw
    data_req(1'b1, 3'b010, 32'h0000_2002, 32'h5A5A_0000);
    wait_aw();
    chk("sh_awsize", axi.awsize, 1);
    chk("sh_wstrb", axi.wstrb, 4'b1100);
    serve_write(2, 0);
    repeat (3) tick();

    // Simultaneous inst fetch and data load: data goes first
    ip0 = inst_pulses; dp0 = data_pulses;
    inst_cb = 1'b1; inst_addr = 32'h0000_1100;
    data_cb = 1'b1; data_en = 1'b1; we = 1'b0; rsize = 3'b100; raddr = 32'h0000_8000;
    tick();
    inst_cb = 1'b0; data_cb = 1'b0;
    wait_ar();
    chk("dual_arid0", axi.arid, 1);
    chk("dual_araddr0", axi.araddr, 32'h0000_8000);
    serve_read(0, 32'h1111_2222);
    wait_ar();
    chk("dual_arid1", axi.arid, 0);
    chk("dual_araddr1", axi.araddr, 32'h0000_1100);
    serve_read(1, 32'h3333_4444);
    repeat (3) tick();
    chk("dual_inst_pulses", inst_pulses - ip0, 1);
    chk("dual_data_pulses", data_pulses - dp0, 1);
    chk("dual_order", data_seq < inst_seq, 1);
    chk("dual_drdata", data_rdata, 32'h1111_2222);
    chk("dual_irdata", inst_rdata, 32'h3333_4444);

    // Half load, fastest slave: return pulse lands 3 cycles after issue
    data_req(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    wait_ar();
    chk("lh_arsize", axi.arsize, 1);
    chk("lh_araddr", axi.araddr, 32'h0000_3002);
    serve_read(0, 32'h1234_5678);
    chk("lh_rr_early", data_rr, 0);
    tick();
    chk("lh_rr_pulse", data_rr, 1);
    tick();
    chk("lh_rr_off", data_rr, 0);
    chk("lh_rdata", data_rdata, 32'h1234_5678);

    // Word store, w handshake 5 cycles after aw
    data_req(1'b1, 3'b100, 32'h0000_2010, 32'hCAFE_F00D);
    wait_aw();
    chk("sw_awsize", axi.awsize, 2);
    chk("sw_wstrb", axi.wstrb, 4'b1111);
    serve_write(0, 5);
    repeat (3) tick();

    // call_begin without enable is not a request
    dp0 = data_pulses;
    data_en = 1'b0; data_cb = 1'b1; we = 1'b0; raddr = 32'h0000_9000;
    tick();
    data_cb = 1'b0; data_en = 1'b1;
    repeat (5) tick();
    chk("noen_arvalid", axi.arvalid, 0);
    chk("noen_pulses", data_pulses - dp0, 0);

    // Asynchronous reset while waiting in RD_DATA
    fetch_req(32'h0000_5000);
    wait_ar();
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    chk("rs_rready_pre", axi.rready, 1);
    tick();
    reset = 1'b0;
    #2;
    chk("rs_rready", axi.rready, 0);
    chk("rs_arvalid", axi.arvalid, 0);
    chk("rs_araddr", axi.araddr, 0);
    chk("rs_awvalid", axi.awvalid, 0);
    chk("rs_irdata", inst_rdata, 0);
    chk("rs_drdata", data_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    ip0 = inst_pulses;
    fetch_req(32'h0000_6000);
    wait_ar();
    chk("rs_fetch_araddr", axi.araddr, 32'h0000_6000);
    serve_read(1, 32'hDEAD_BEEF);
    repeat (3) tick();
    chk("rs_fetch_pulses", inst_pulses - ip0, 1);
    chk("rs_fetch_rdata", inst_rdata, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
